instr_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the control decoder. Walks a PC over the

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_if.sv | 33 +++
 rtl/fetch_queue.sv | 52 +++++
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Contents: opcode encodings, the instruction word layout and the fetch FSM states.
package fetch_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_DIV  = 3'b010,
        OP_MUL  = 3'b011,
        OP_MCLR = 3'b100,
        OP_HALT = 3'b101,
        OP_MRD  = 3'b110,
        OP_MWR  = 3'b111
    } opcode_e;

    // Field layout: OPC 31:29, SRCA 28:27, DEST 26:25, IMM 24:0.
    typedef struct packed {
        opcode_e     opc;
        logic [1:0]  srca;
        logic [1:0]  dest;
        logic [24:0] imm;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Control, instruction-memory and decoder-side signals of the fetch unit.
// FETCH_INSTR_COUNT_EN adds the _instr_count transfer counter.
interface fetch_if #(parameter int ADDR_W = 8);
    logic              _start;
    logic [ADDR_W-1:0] _start_addr;
    logic              _imem_req;
    logic [ADDR_W-1:0] _imem_addr;
    logic [31:0]       _imem_data;
    logic [31:0]       _instrucao;
    logic              _instr_valid;
    logic              _instr_ready;
    logic [ADDR_W-1:0] _pc_out;
    logic              _halted;
`ifdef FETCH_INSTR_COUNT_EN
    logic [31:0]       _instr_count;
`endif

    modport master (
        input  _start, _start_addr, _imem_data, _instr_ready,
        output _imem_req, _imem_addr, _instrucao, _instr_valid, _pc_out, _halted
`ifdef FETCH_INSTR_COUNT_EN
        , output _instr_count
`endif
    );

    modport slave (
        output _start, _start_addr, _imem_data, _instr_ready,
        input  _imem_req, _imem_addr, _instrucao, _instr_valid, _pc_out, _halted
`ifdef FETCH_INSTR_COUNT_EN
        , input _instr_count
`endif
    );
endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO: DEPTH entries of W bits, head shown combinationally from storage.
// Push and pop may coincide, including when full.
module fetch_queue #(
    parameter  int DEPTH = 4,
    parameter  int W     = 40,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          _clock,
    input  logic          _reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; empty gates every use of dout.
    always_ff @(posedge _clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: walks the PC over synchronous imem, buffers words, strips HALT.
// Optional FETCH_INSTR_COUNT_EN adds a 32-bit count of decoder transfers.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input logic    _clock,
    input logic    _reset_n,
    fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] resp_addr;
    logic              inflight;
    logic              discard;
    logic              resp_live;
    logic              resp_halt;
    logic              start_ok;
    logic              push;
    logic              pop;
    logic [CW-1:0]     q_count;
    logic              q_empty;
    logic              q_full;
    logic [31+ADDR_W:0] q_dout;

    assign resp_live = inflight && !discard;
    assign resp_halt = resp_live && (bus._imem_data[31:29] == OP_HALT);
    assign push      = resp_live && !resp_halt;
    assign pop       = bus._instr_valid && bus._instr_ready;
    assign start_ok  = bus._start && (state == ST_IDLE || state == ST_HALTED);

    // Counting the in-flight word keeps a slot free for every response still on its way.
    assign bus._imem_req  = (state == ST_RUN) && ((q_count + CW'(inflight)) < CW'(DEPTH));
    assign bus._imem_addr = pc;

    // NOTE: combinational logic assigns defaults first with blocking '=' so no latch is
    // inferred; all sequential state below uses '<='.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_HALTED: if (bus._start) state_nxt = ST_RUN;
            ST_RUN:             if (resp_halt)  state_nxt = ST_DRAIN;
            ST_DRAIN:           if (q_empty)    state_nxt = ST_HALTED;
            default:                            state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state     <= ST_IDLE;
            pc        <= '0;
            resp_addr <= '0;
            inflight  <= 1'b0;
            discard   <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= bus._imem_req;
            if (bus._imem_req) begin
                resp_addr <= pc;
                pc        <= pc + 1'b1;
            end else if (start_ok) begin
                pc <= bus._start_addr;
            end
            // A request issued alongside the returning HALT fetches a word past the program.
            if (inflight && discard) discard <= 1'b0;
            else if (resp_halt)      discard <= bus._imem_req;
        end
    end

    fetch_queue #(.DEPTH(DEPTH), .W(32 + ADDR_W)) u_queue (
        ._clock   (_clock),
        ._reset_n (_reset_n),
        .push     (push),
        .pop      (pop),
        .din      ({resp_addr, bus._imem_data}),
        .dout     (q_dout),
        .count    (q_count),
        .empty    (q_empty),
        .full     (q_full)
    );

    assign bus._instr_valid = !q_empty;
    assign bus._instrucao   = q_empty ? 32'h0 : q_dout[31:0];
    assign bus._pc_out      = q_empty ? '0 : q_dout[31+ADDR_W:32];
    assign bus._halted      = (state == ST_HALTED);

    overflow_guard: assert property (@(posedge _clock) disable iff (!_reset_n)
        !(push && q_full && !pop));

`ifdef FETCH_INSTR_COUNT_EN
    logic [31:0] instr_count;

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n)     instr_count <= '0;
        else if (start_ok) instr_count <= '0;
        else if (pop)      instr_count <= instr_count + 1'b1;
    end

    assign bus._instr_count = instr_count;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed programs, expected words queued at load time.
// A negedge monitor pops and compares every decoder transfer.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem [256];
    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          xfers = 0;

    fetch_if #(.ADDR_W(8)) bus ();

    instr_fetch_unit #(.ADDR_W(8), .DEPTH(4)) dut (
        ._clock   (clk),
        ._reset_n (rst_n),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data valid the cycle after the request.
    always @(posedge clk) begin
        if (bus._imem_req) bus._imem_data <= imem[bus._imem_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus._instr_valid && bus._instr_ready) begin
            xfers++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: pc=%0h word=%0h with nothing expected",
                         bus._pc_out, bus._instrucao);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("xfer_pc", bus._pc_out, e.pc);
                check("xfer_word", bus._instrucao, e.word);
            end
        end
    end

    function automatic logic [31:0] mk(input opcode_e op, input logic [24:0] imm);
        instr_t i;
        i.opc  = op;
        i.srca = 2'd1;
        i.dest = 2'd2;
        i.imm  = imm;
        return i;
    endfunction

    task automatic load(input logic [7:0] a, input logic [31:0] w, input bit want);
        imem[a] = w;
        if (want) exp_q.push_back('{pc: a, word: w});
    endtask

    // Returns 1 ns after the edge that sampled _start.
    task automatic pulse_start(input logic [7:0] a);
        @(posedge clk); #1;
        bus._start      = 1'b1;
        bus._start_addr = a;
        @(posedge clk); #1;
        bus._start      = 1'b0;
    endtask

    task automatic wait_halted(input string name);
        int n = 0;
        while (!bus._halted && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, bus._halted, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap;
        for (int i = 0; i < 256; i++) imem[i] = mk(OP_MUL, 25'(i));
        bus._start       = 1'b0;
        bus._start_addr  = 8'h00;
        bus._instr_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", bus._instr_valid, 1'b0);
        check("rst_req", bus._imem_req, 1'b0);
        check("rst_instrucao", bus._instrucao, 32'h0);
        check("rst_pc_out", bus._pc_out, 8'h00);
        check("rst_halted", bus._halted, 1'b0);
        rst_n = 1'b1;

        // Program at 0: three words delivered, HALT consumed, word after HALT dropped
        load(8'h00, mk(OP_ADD, 25'h11), 1);
        load(8'h01, mk(OP_SUB, 25'h22), 1);
        load(8'h02, mk(OP_MUL, 25'h33), 1);
        load(8'h03, mk(OP_HALT, 25'h0), 0);
        load(8'h04, mk(OP_ADD, 25'h44), 0);
        bus._instr_ready = 1'b1;
        pulse_start(8'h00);
        wait_halted("s1_halted");
        repeat (4) @(negedge clk);
        check("s1_valid_after_halt", bus._instr_valid, 1'b0);
        check("s1_all_words_seen", exp_q.size(), 0);
`ifdef FETCH_INSTR_COUNT_EN
        check("s1_instr_count", bus._instr_count, 32'd3);
`endif

        // Backpressure: queue fills to 4 and holds, then drains at one word per cycle
        for (int i = 0; i < 12; i++) load(8'(8'h20 + i), mk(OP_ADD, 25'(16'h2000 + i)), 1);
        load(8'h2C, mk(OP_HALT, 25'h0), 0);
        bus._instr_ready = 1'b0;
        pulse_start(8'h20);
`ifdef FETCH_INSTR_COUNT_EN
        check("s2_count_cleared", bus._instr_count, 32'd0);
`endif
        repeat (7) @(negedge clk);
        check("s2_req_low_full", bus._imem_req, 1'b0);
        check("s2_head_pc_early", bus._pc_out, 8'h20);
        repeat (3) @(negedge clk);
        check("s2_valid_held", bus._instr_valid, 1'b1);
        check("s2_req_low_late", bus._imem_req, 1'b0);
        check("s2_head_pc_late", bus._pc_out, 8'h20);
        check("s2_head_word_late", bus._instrucao, mk(OP_ADD, 25'h2000));
        @(posedge clk); #1;
        bus._instr_ready = 1'b1;
        snap = xfers;
        repeat (12) @(negedge clk);
        #1;
        check("s2_back_to_back", xfers - snap, 12);
        wait_halted("s2_halted");
        check("s2_all_words_seen", exp_q.size(), 0);

        // PC wrap from FF to 00
        load(8'hFE, mk(OP_ADD, 25'hFE), 1);
        load(8'hFF, mk(OP_SUB, 25'hFF), 1);
        load(8'h00, mk(OP_DIV, 25'h100), 1);
        load(8'h01, mk(OP_HALT, 25'h0), 0);
        pulse_start(8'hFE);
        wait_halted("s3_halted");
        check("s3_all_words_seen", exp_q.size(), 0);

        // Asynchronous reset with three words queued, then a clean restart
        for (int i = 0; i < 6; i++) load(8'(8'h40 + i), mk(OP_SUB, 25'(16'h4000 + i)), 0);
        bus._instr_ready = 1'b0;
        pulse_start(8'h40);
        repeat (4) @(posedge clk);
        #2;
        check("s4_valid_before_rst", bus._instr_valid, 1'b1);
        check("s4_head_before_rst", bus._pc_out, 8'h40);
        rst_n = 1'b0;
        #1;
        check("s4_rst_valid", bus._instr_valid, 1'b0);
        check("s4_rst_req", bus._imem_req, 1'b0);
        check("s4_rst_pc_out", bus._pc_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        load(8'h50, mk(OP_MRD, 25'h50), 1);
        load(8'h51, mk(OP_HALT, 25'h0), 0);
        bus._instr_ready = 1'b1;
        pulse_start(8'h50);
        wait_halted("s4_halted");
        check("s4_all_words_seen", exp_q.size(), 0);

        // _start during RUN is ignored
        for (int i = 0; i < 6; i++) load(8'(8'h60 + i), mk(OP_MWR, 25'(16'h6000 + i)), 1);
        load(8'h66, mk(OP_HALT, 25'h0), 0);
        load(8'h80, mk(OP_ADD, 25'h80), 0);
        pulse_start(8'h60);
        pulse_start(8'h80);
        wait_halted("s5_halted");
        check("s5_all_words_seen", exp_q.size(), 0);

        // Restart from HALTED at 0x10: first word valid two edges after _start is sampled
        load(8'h10, mk(OP_MCLR, 25'h10), 1);
        load(8'h11, mk(OP_HALT, 25'h0), 0);
        bus._instr_ready = 1'b0;
        pulse_start(8'h10);
        @(negedge clk);
        check("s5_req_t0", bus._imem_req, 1'b1);
        check("s5_addr_t0", bus._imem_addr, 8'h10);
        check("s5_halted_cleared", bus._halted, 1'b0);
        check("s5_valid_t0", bus._instr_valid, 1'b0);
        @(negedge clk);
        check("s5_valid_t1", bus._instr_valid, 1'b0);
        @(negedge clk);
        check("s5_valid_t2", bus._instr_valid, 1'b1);
        check("s5_pc_t2", bus._pc_out, 8'h10);
        @(posedge clk); #1;
        bus._instr_ready = 1'b1;
        wait_halted("s5_halted_again");
        check("s5_restart_words_seen", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
